// File: rtl/decode_issue_unit.sv
// WISC decode/issue stage: registered ID output with valid/ready handshake,
// a per-register pending-write scoreboard for RAW/WAW interlocks, flush rollback and sticky halt.
module decode_issue_unit #(
  parameter int REG_W   = 4,
  parameter int CNT_W   = 2,
  parameter int R0_ZERO = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [15:0]        if_inst,
  input  logic [15:0]        if_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [15:0]        id_inst,
  output logic [15:0]        id_pc,
  output logic [REG_W-1:0]   id_rd,
  output logic [REG_W-1:0]   id_src1,
  output logic [REG_W-1:0]   id_src2,
  output logic               id_wen,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_rd,
  output logic               hazard,
  output logic               halted,
  output logic               sb_underflow,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int NUM_REGS = 2**REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W+1:0] STEP    = (CNT_W+2)'(1);

  logic [CNT_W-1:0] pend     [NUM_REGS];
  logic [CNT_W-1:0] pend_nxt [NUM_REGS];

  logic [3:0]       opcode;
  logic [REG_W-1:0] f_rd, f_rs, f_rt;
  logic [REG_W-1:0] dec_src1, dec_src2;
  logic             reads1, reads2, dec_wen;
  logic [CNT_W-1:0] p1, p2, pd;
  logic             raw1, raw2, waw;
  logic             accept;
  logic             underflow_any;
  logic [CNT_W+1:0] sum;
  logic             hit_inc, hit_wb, hit_rb;

  function automatic logic is_tracked(input logic [REG_W-1:0] r);
    return !((R0_ZERO != 0) && (r == '0));
  endfunction

  assign opcode = if_inst[15:12];
  assign f_rd   = REG_W'(if_inst[11:8]);
  assign f_rs   = REG_W'(if_inst[7:4]);
  assign f_rt   = REG_W'(if_inst[3:0]);

  // Source selection and write-enable by opcode class; all-zero word is a true NOP.
  always_comb begin
    dec_src1 = '0;
    dec_src2 = '0;
    reads1   = 1'b0;
    reads2   = 1'b0;
    dec_wen  = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        dec_src1 = f_rs; dec_src2 = f_rt; reads1 = 1'b1; reads2 = 1'b1;
      end
      4'h4, 4'h5, 4'h6, 4'h8, 4'hD: begin
        dec_src1 = f_rs; reads1 = 1'b1;
      end
      4'h9: begin
        dec_src1 = f_rs; dec_src2 = f_rd; reads1 = 1'b1; reads2 = 1'b1;
      end
      4'hA, 4'hB: begin
        dec_src1 = f_rd; reads1 = 1'b1;
      end
      default: ;
    endcase
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
      4'hA, 4'hB, 4'hE: dec_wen = 1'b1;
      default:          dec_wen = 1'b0;
    endcase
    if (if_inst == 16'h0000) begin
      dec_src1 = '0;
      dec_src2 = '0;
      reads1   = 1'b0;
      reads2   = 1'b0;
      dec_wen  = 1'b0;
    end
  end

  // A single outstanding write being retired this cycle is forwarded by the regfile.
  always_comb begin
    p1   = pend[dec_src1];
    p2   = pend[dec_src2];
    pd   = pend[f_rd];
    raw1 = reads1 && is_tracked(dec_src1) && (p1 != '0) &&
           !((p1 == CNT_ONE) && wb_valid && (wb_rd == dec_src1));
    raw2 = reads2 && is_tracked(dec_src2) && (p2 != '0) &&
           !((p2 == CNT_ONE) && wb_valid && (wb_rd == dec_src2));
    waw  = dec_wen && is_tracked(f_rd) && (pd == CNT_MAX);
    hazard = if_valid && (raw1 || raw2 || waw);
  end

  assign if_ready = !rst && !flush && !halted && !hazard && (!id_valid || id_ready);
  assign accept   = if_valid && if_ready;

  // Net per-register change; a negative result clamps to zero and flags underflow.
  always_comb begin
    underflow_any = 1'b0;
    sum     = '0;
    hit_inc = 1'b0;
    hit_wb  = 1'b0;
    hit_rb  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      hit_inc = accept && dec_wen && (f_rd == REG_W'(r)) && is_tracked(REG_W'(r));
      hit_wb  = wb_valid && (wb_rd == REG_W'(r)) && is_tracked(REG_W'(r));
      hit_rb  = flush && id_valid && id_wen && (id_rd == REG_W'(r)) && is_tracked(REG_W'(r));
      sum = {2'b00, pend[r]};
      if (hit_inc) sum = sum + STEP;
      if (hit_wb)  sum = sum - STEP;
      if (hit_rb)  sum = sum - STEP;
      if (sum[CNT_W+1]) begin
        pend_nxt[r]   = '0;
        underflow_any = 1'b1;
      end else begin
        pend_nxt[r] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_inst  <= '0;
      id_pc    <= '0;
      id_rd    <= '0;
      id_src1  <= '0;
      id_src2  <= '0;
      id_wen   <= 1'b0;
    end else if (accept) begin
      id_valid <= 1'b1;
      id_inst  <= if_inst;
      id_pc    <= if_pc;
      id_rd    <= f_rd;
      id_src1  <= dec_src1;
      id_src2  <= dec_src2;
      id_wen   <= dec_wen;
    end else if (flush || id_ready) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted       <= 1'b0;
      sb_underflow <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (accept && (opcode == 4'hF)) halted <= 1'b1;
      if (underflow_any) sb_underflow <= 1'b1;
      if (hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule
